// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
// Shared definitions for the IF/MEM memory port arbiter: FSM state
// encoding and default bus widths.
package mem_bus_arbiter_pkg;

    localparam int unsigned ARB_ADDR_W = 32;
    localparam int unsigned ARB_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_D_ADDR,
        ST_D_WAIT,
        ST_I_ADDR,
        ST_I_WAIT
    } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
// Groups the pipeline-side request/response signals, hazard-unit signals
// and the SRAM-like memory port used by mem_bus_arbiter.
//   master : arbiter view (drives responses, stall requests, bus request)
//   slave  : environment view (pipeline stages, hazard unit, memory)
interface mem_bus_arbiter_if
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ARB_ADDR_W,
    parameter int unsigned DATA_W = ARB_DATA_W
) ();
    // instruction fetch side
    logic                  inst_req;
    logic [ADDR_W-1:0]     inst_addr;
    logic [DATA_W-1:0]     inst_rdata;
    logic                  inst_ok;
    // data access side
    logic                  data_req;
    logic                  data_wr;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W/8-1:0]   data_wstrb;
    logic [DATA_W-1:0]     data_wdata;
    logic [DATA_W-1:0]     data_rdata;
    logic                  data_ok_o;
    // hazard unit
    logic                  if_stall;
    logic                  mem_stall;
    logic                  flush;
    logic                  stallreq_from_if;
    logic                  stallreq_from_mem;
    // memory port
    logic                  bus_req;
    logic                  bus_wr;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W/8-1:0]   bus_wstrb;
    logic [DATA_W-1:0]     bus_wdata;
    logic                  bus_addr_ok;
    logic                  bus_data_ok;
    logic [DATA_W-1:0]     bus_rdata;

    modport master (
        input  inst_req, inst_addr, data_req, data_wr, data_addr, data_wstrb,
               data_wdata, if_stall, mem_stall, flush, bus_addr_ok,
               bus_data_ok, bus_rdata,
        output inst_rdata, inst_ok, data_rdata, data_ok_o, stallreq_from_if,
               stallreq_from_mem, bus_req, bus_wr, bus_addr, bus_wstrb,
               bus_wdata
    );

    modport slave (
        output inst_req, inst_addr, data_req, data_wr, data_addr, data_wstrb,
               data_wdata, if_stall, mem_stall, flush, bus_addr_ok,
               bus_data_ok, bus_rdata,
        input  inst_rdata, inst_ok, data_rdata, data_ok_o, stallreq_from_if,
               stallreq_from_mem, bus_req, bus_wr, bus_addr, bus_wstrb,
               bus_wdata
    );

endinterface

// File: rtl/mem_bus_arbiter_hold_buf.sv
// arb_hold_buf
// Holds a completed read result while the consuming stage is frozen.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : capture data_i (completion seen while stalled)
//   data_i     : read data to capture
//   stall_i    : consuming stage frozen
//   clear_i    : drop any held result (flush)
//   valid_o    : result held
//   data_o     : held result
module arb_hold_buf #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         stall_i,
    input  logic         clear_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // The held result stays visible through the first unstalled cycle
    // (the stage consumes it then) and disappears the cycle after.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && !stall_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one SRAM-like memory port between instruction fetch and data
// access, one outstanding transaction at a time, data first.
//   clk, resetn : clock, asynchronous active-low reset
//   bus         : mem_bus_arbiter_if.master (pipeline, hazard, memory port)
//   perf_inst_stall, perf_data_stall : stall-cycle counters, present only
//                 when BUS_ARB_PERF_EN is defined
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ARB_ADDR_W,
    parameter int unsigned DATA_W = ARB_DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    mem_bus_arbiter_if.master bus
`ifdef BUS_ARB_PERF_EN
    ,
    output logic [31:0]       perf_inst_stall,
    output logic [31:0]       perf_data_stall
`endif
);
    arb_state_e            state_q, state_d;
    logic                  wr_q, wr_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  disc_q, disc_d;

    logic                  inst_done, data_done, inst_fresh;
    logic                  ibuf_valid, dbuf_valid;
    logic [DATA_W-1:0]     ibuf_data, dbuf_data;
    logic                  inst_ok, data_ok;
    logic                  stall_if, stall_mem;

    assign inst_done  = (state_q == ST_I_WAIT) && bus.bus_data_ok;
    assign data_done  = (state_q == ST_D_WAIT) && bus.bus_data_ok;
    // A fetch flushed at any point up to and including its completion
    // cycle is dropped.
    assign inst_fresh = inst_done && !disc_q && !bus.flush;

    arb_hold_buf #(.W(DATA_W)) u_inst_buf (
        .clk     (clk),
        .rst_n   (resetn),
        .load_i  (inst_fresh && bus.if_stall),
        .data_i  (bus.bus_rdata),
        .stall_i (bus.if_stall),
        .clear_i (bus.flush),
        .valid_o (ibuf_valid),
        .data_o  (ibuf_data)
    );

    arb_hold_buf #(.W(DATA_W)) u_data_buf (
        .clk     (clk),
        .rst_n   (resetn),
        .load_i  (data_done && bus.mem_stall),
        .data_i  (bus.bus_rdata),
        .stall_i (bus.mem_stall),
        .clear_i (1'b0),
        .valid_o (dbuf_valid),
        .data_o  (dbuf_data)
    );

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        disc_d  = disc_q;
        unique case (state_q)
            ST_IDLE: begin
                // A requester still holding a buffered result is not re-served.
                if (bus.data_req && !dbuf_valid) begin
                    state_d = ST_D_ADDR;
                    wr_d    = bus.data_wr;
                    addr_d  = bus.data_addr;
                    wstrb_d = bus.data_wstrb;
                    wdata_d = bus.data_wdata;
                end else if (bus.inst_req && !ibuf_valid) begin
                    state_d = ST_I_ADDR;
                    wr_d    = 1'b0;
                    addr_d  = bus.inst_addr;
                    wstrb_d = '0;
                    wdata_d = '0;
                end
            end
            ST_D_ADDR: if (bus.bus_addr_ok) state_d = ST_D_WAIT;
            ST_D_WAIT: if (bus.bus_data_ok) state_d = ST_IDLE;
            ST_I_ADDR: if (bus.bus_addr_ok) state_d = ST_I_WAIT;
            ST_I_WAIT: if (bus.bus_data_ok) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (inst_done) begin
            disc_d = 1'b0;
        end else if (bus.flush && (state_q == ST_I_ADDR || state_q == ST_I_WAIT)) begin
            disc_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            disc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            disc_q  <= disc_d;
        end
    end

    assign inst_ok   = inst_fresh || (ibuf_valid && !bus.flush);
    assign data_ok   = data_done || dbuf_valid;
    assign stall_if  = bus.inst_req && !inst_ok;
    assign stall_mem = bus.data_req && !data_ok;

    assign bus.inst_ok           = inst_ok;
    assign bus.inst_rdata        = !inst_ok ? '0 : (ibuf_valid ? ibuf_data : bus.bus_rdata);
    assign bus.data_ok_o         = data_ok;
    assign bus.data_rdata        = !data_ok ? '0 : (dbuf_valid ? dbuf_data : bus.bus_rdata);
    assign bus.stallreq_from_if  = stall_if;
    assign bus.stallreq_from_mem = stall_mem;
    assign bus.bus_req           = (state_q == ST_D_ADDR) || (state_q == ST_I_ADDR);
    assign bus.bus_wr            = wr_q;
    assign bus.bus_addr          = addr_q;
    assign bus.bus_wstrb         = wstrb_q;
    assign bus.bus_wdata         = wdata_q;

`ifdef BUS_ARB_PERF_EN
    logic [31:0] perf_inst_q, perf_data_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_inst_q <= '0;
            perf_data_q <= '0;
        end else begin
            if (stall_if)  perf_inst_q <= perf_inst_q + 32'd1;
            if (stall_mem) perf_data_q <= perf_data_q + 32'd1;
        end
    end

    assign perf_inst_stall = perf_inst_q;
    assign perf_data_stall = perf_data_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

`ifdef BUS_ARB_PERF_EN
    logic [31:0] perf_i, perf_d;
`endif

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if)
`ifdef BUS_ARB_PERF_EN
        ,
        .perf_inst_stall (perf_i),
        .perf_data_stall (perf_d)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    typedef struct {
        logic        is_data;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int unsigned aok_dly;
        int unsigned dok_dly;
        logic [31:0] rsp;
        logic        exp_wr;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [5];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v);
        logic fin;
        @(negedge clk);
        if (v.is_data) begin
            bus_if.data_req   = 1'b1;
            bus_if.data_wr    = v.wr;
            bus_if.data_addr  = v.addr;
            bus_if.data_wstrb = v.wstrb;
            bus_if.data_wdata = v.wdata;
        end else begin
            bus_if.inst_req  = 1'b1;
            bus_if.inst_addr = v.addr;
        end
        #1;
        chk1("idle_bus_req", bus_if.bus_req, 1'b0);
        chk1("idle_stallreq", v.is_data ? bus_if.stallreq_from_mem : bus_if.stallreq_from_if, 1'b1);
        for (int unsigned d = 0; d <= v.aok_dly; d++) begin
            @(negedge clk);
            bus_if.bus_addr_ok = (d == v.aok_dly);
            #1;
            chk1("addr_bus_req", bus_if.bus_req, 1'b1);
            chk32("addr_bus_addr", bus_if.bus_addr, v.addr);
            chk1("addr_bus_wr", bus_if.bus_wr, v.exp_wr);
            chk32("addr_bus_wstrb", {28'd0, bus_if.bus_wstrb}, {28'd0, v.exp_wstrb});
            chk32("addr_bus_wdata", bus_if.bus_wdata, v.exp_wdata);
        end
        for (int unsigned d = 0; d <= v.dok_dly; d++) begin
            @(negedge clk);
            fin = (d == v.dok_dly);
            bus_if.bus_addr_ok = 1'b0;
            bus_if.bus_data_ok = fin;
            bus_if.bus_rdata   = fin ? v.rsp : 32'hFFFF_FFFF;
            #1;
            chk1("wait_bus_req", bus_if.bus_req, 1'b0);
            if (v.is_data) begin
                chk1("wait_data_ok", bus_if.data_ok_o, fin);
                chk1("wait_stallreq_mem", bus_if.stallreq_from_mem, !fin);
                if (fin) chk32("done_data_rdata", bus_if.data_rdata, v.exp_rdata);
            end else begin
                chk1("wait_inst_ok", bus_if.inst_ok, fin);
                chk1("wait_stallreq_if", bus_if.stallreq_from_if, !fin);
                if (fin) chk32("done_inst_rdata", bus_if.inst_rdata, v.exp_rdata);
            end
        end
        @(negedge clk);
        bus_if.bus_data_ok = 1'b0;
        bus_if.inst_req    = 1'b0;
        bus_if.data_req    = 1'b0;
        #1;
        chk1("post_inst_ok", bus_if.inst_ok, 1'b0);
        chk1("post_data_ok", bus_if.data_ok_o, 1'b0);
        chk1("post_bus_req", bus_if.bus_req, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        bus_if.inst_req    = 1'b0;
        bus_if.inst_addr   = '0;
        bus_if.data_req    = 1'b0;
        bus_if.data_wr     = 1'b0;
        bus_if.data_addr   = '0;
        bus_if.data_wstrb  = '0;
        bus_if.data_wdata  = '0;
        bus_if.if_stall    = 1'b0;
        bus_if.mem_stall   = 1'b0;
        bus_if.flush       = 1'b0;
        bus_if.bus_addr_ok = 1'b0;
        bus_if.bus_data_ok = 1'b0;
        bus_if.bus_rdata   = '0;

        //          data  wr    addr          wstrb    wdata         aok dok rsp           exp_wr exp_wstrb exp_wdata     exp_rdata
        vecs[0] = '{1'b0, 1'b0, 32'hBFC00000, 4'b0000, 32'h00000000, 0,  2,  32'h3C080001, 1'b0,  4'b0000,  32'h00000000, 32'h3C080001};
        vecs[1] = '{1'b1, 1'b0, 32'h80001000, 4'b1111, 32'h00000000, 1,  0,  32'h12345678, 1'b0,  4'b1111,  32'h00000000, 32'h12345678};
        vecs[2] = '{1'b1, 1'b1, 32'h80002004, 4'b0011, 32'h0000BEEF, 0,  1,  32'h00000000, 1'b1,  4'b0011,  32'h0000BEEF, 32'h00000000};
        vecs[3] = '{1'b0, 1'b0, 32'hBFC00004, 4'b0000, 32'h00000000, 2,  0,  32'hDEADBEEF, 1'b0,  4'b0000,  32'h00000000, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 1'b1, 32'h80000010, 4'b1111, 32'hA5A5A5A5, 1,  1,  32'h00000000, 1'b1,  4'b1111,  32'hA5A5A5A5, 32'h00000000};

        // reset state, requests already pending
        @(negedge clk);
        bus_if.inst_req = 1'b1;
        bus_if.data_req = 1'b1;
        #1;
        chk1("rst_bus_req", bus_if.bus_req, 1'b0);
        chk1("rst_inst_ok", bus_if.inst_ok, 1'b0);
        chk1("rst_data_ok", bus_if.data_ok_o, 1'b0);
        chk32("rst_inst_rdata", bus_if.inst_rdata, 32'h0);
        chk32("rst_bus_addr", bus_if.bus_addr, 32'h0);
        chk1("rst_stallreq_if", bus_if.stallreq_from_if, 1'b1);
        chk1("rst_stallreq_mem", bus_if.stallreq_from_mem, 1'b1);
        @(negedge clk);
        bus_if.inst_req = 1'b0;
        bus_if.data_req = 1'b0;
        resetn = 1'b1;

        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // simultaneous requests: data served first, IF stalled throughout
        @(negedge clk);
        bus_if.inst_req = 1'b1; bus_if.inst_addr = 32'hBFC00010;
        bus_if.data_req = 1'b1; bus_if.data_wr = 1'b0; bus_if.data_addr = 32'h80001000;
        bus_if.data_wstrb = 4'b1111; bus_if.data_wdata = '0;
        #1 chk1("both_idle_sif", bus_if.stallreq_from_if, 1'b1);
        @(negedge clk); bus_if.bus_addr_ok = 1'b1;
        #1 chk32("both_first_addr", bus_if.bus_addr, 32'h80001000);
        chk1("both_d_sif", bus_if.stallreq_from_if, 1'b1);
        @(negedge clk); bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'hCAFE0001;
        #1 chk1("both_data_ok", bus_if.data_ok_o, 1'b1);
        chk32("both_data_rdata", bus_if.data_rdata, 32'hCAFE0001);
        chk1("both_inst_ok_low", bus_if.inst_ok, 1'b0);
        chk1("both_dw_sif", bus_if.stallreq_from_if, 1'b1);
        @(negedge clk); bus_if.data_req = 1'b0; bus_if.bus_data_ok = 1'b0;
        #1 chk1("both_gap_req", bus_if.bus_req, 1'b0);
        chk1("both_gap_sif", bus_if.stallreq_from_if, 1'b1);
        @(negedge clk); bus_if.bus_addr_ok = 1'b1;
        #1 chk32("both_second_addr", bus_if.bus_addr, 32'hBFC00010);
        @(negedge clk); bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'h11112222;
        #1 chk1("both_inst_ok", bus_if.inst_ok, 1'b1);
        chk32("both_inst_rdata", bus_if.inst_rdata, 32'h11112222);
        chk1("both_iw_sif", bus_if.stallreq_from_if, 1'b0);
        @(negedge clk); bus_if.inst_req = 1'b0; bus_if.bus_data_ok = 1'b0;

        // load completes while MEM is frozen: result held, no re-issue
        @(negedge clk);
        bus_if.data_req = 1'b1; bus_if.data_wr = 1'b0; bus_if.data_addr = 32'h80001000;
        @(negedge clk); bus_if.bus_addr_ok = 1'b1;
        @(negedge clk); bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b1;
        bus_if.bus_rdata = 32'h0BADF00D; bus_if.mem_stall = 1'b1;
        #1 chk1("hold_done_ok", bus_if.data_ok_o, 1'b1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk); bus_if.bus_data_ok = 1'b0; bus_if.bus_rdata = 32'hFFFF_FFFF;
            #1 chk1("hold_ok", bus_if.data_ok_o, 1'b1);
            chk32("hold_rdata", bus_if.data_rdata, 32'h0BADF00D);
            chk1("hold_no_reissue", bus_if.bus_req, 1'b0);
            chk1("hold_smem", bus_if.stallreq_from_mem, 1'b0);
        end
        @(negedge clk); bus_if.mem_stall = 1'b0;
        #1 chk1("hold_release_ok", bus_if.data_ok_o, 1'b1);
        chk32("hold_release_rdata", bus_if.data_rdata, 32'h0BADF00D);
        chk1("hold_release_req", bus_if.bus_req, 1'b0);
        @(negedge clk); bus_if.data_req = 1'b0;
        #1 chk1("hold_cleared", bus_if.data_ok_o, 1'b0);
        chk1("hold_after_req", bus_if.bus_req, 1'b0);

        // flush during I_WAIT: response swallowed, next fetch normal
        @(negedge clk); bus_if.inst_req = 1'b1; bus_if.inst_addr = 32'hBFC00100;
        @(negedge clk); bus_if.bus_addr_ok = 1'b1;
        @(negedge clk); bus_if.bus_addr_ok = 1'b0; bus_if.flush = 1'b1;
        #1 chk1("fl_wait_ok", bus_if.inst_ok, 1'b0);
        @(negedge clk); bus_if.flush = 1'b0; bus_if.inst_addr = 32'hBFC00380;
        bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'h33333333;
        #1 chk1("fl_discard_ok", bus_if.inst_ok, 1'b0);
        chk1("fl_discard_sif", bus_if.stallreq_from_if, 1'b1);
        @(negedge clk); bus_if.bus_data_ok = 1'b0;
        #1 chk1("fl_idle_req", bus_if.bus_req, 1'b0);
        @(negedge clk); bus_if.bus_addr_ok = 1'b1;
        #1 chk32("fl_next_addr", bus_if.bus_addr, 32'hBFC00380);
        @(negedge clk); bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'h24020001;
        #1 chk1("fl_next_ok", bus_if.inst_ok, 1'b1);
        chk32("fl_next_rdata", bus_if.inst_rdata, 32'h24020001);
        @(negedge clk); bus_if.bus_data_ok = 1'b0; bus_if.inst_req = 1'b0;

        // flush in the same cycle as the fetch response
        @(negedge clk); bus_if.inst_req = 1'b1; bus_if.inst_addr = 32'hBFC00384;
        @(negedge clk); bus_if.bus_addr_ok = 1'b1;
        @(negedge clk); bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b1;
        bus_if.bus_rdata = 32'h44444444; bus_if.flush = 1'b1;
        #1 chk1("flsame_ok", bus_if.inst_ok, 1'b0);
        @(negedge clk); bus_if.bus_data_ok = 1'b0; bus_if.flush = 1'b0; bus_if.inst_req = 1'b0;
        #1 chk1("flsame_after_ok", bus_if.inst_ok, 1'b0);

        // flush clears a held fetch result
        @(negedge clk); bus_if.inst_req = 1'b1; bus_if.inst_addr = 32'hBFC00388; bus_if.if_stall = 1'b1;
        @(negedge clk); bus_if.bus_addr_ok = 1'b1;
        @(negedge clk); bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'h55555555;
        #1 chk1("ibuf_done_ok", bus_if.inst_ok, 1'b1);
        @(negedge clk); bus_if.bus_data_ok = 1'b0;
        #1 chk32("ibuf_held_rdata", bus_if.inst_rdata, 32'h55555555);
        @(negedge clk); bus_if.flush = 1'b1;
        #1 chk1("ibuf_flush_ok", bus_if.inst_ok, 1'b0);
        @(negedge clk); bus_if.flush = 1'b0; bus_if.inst_req = 1'b0;
        #1 chk1("ibuf_cleared_ok", bus_if.inst_ok, 1'b0);
        @(negedge clk); bus_if.if_stall = 1'b0;

        // store with flush in D_WAIT still completes
        @(negedge clk);
        bus_if.data_req = 1'b1; bus_if.data_wr = 1'b1; bus_if.data_addr = 32'h80003000;
        bus_if.data_wstrb = 4'b0011; bus_if.data_wdata = 32'h0000BEEF;
        @(negedge clk); bus_if.bus_addr_ok = 1'b1;
        #1 chk32("st_wstrb", {28'd0, bus_if.bus_wstrb}, 32'h3);
        chk32("st_wdata", bus_if.bus_wdata, 32'h0000BEEF);
        chk1("st_wr", bus_if.bus_wr, 1'b1);
        @(negedge clk); bus_if.bus_addr_ok = 1'b0; bus_if.flush = 1'b1;
        @(negedge clk); bus_if.flush = 1'b0; bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = '0;
        #1 chk1("st_flush_ok", bus_if.data_ok_o, 1'b1);
        @(negedge clk); bus_if.bus_data_ok = 1'b0; bus_if.data_req = 1'b0;

        // reset asserted during D_ADDR
        @(negedge clk); bus_if.data_req = 1'b1; bus_if.data_wr = 1'b0; bus_if.data_addr = 32'h80004000;
        @(negedge clk);
        #1 chk1("rstmid_pre_req", bus_if.bus_req, 1'b1);
        #2 resetn = 1'b0;
        #1 chk1("rstmid_async_req", bus_if.bus_req, 1'b0);
        @(negedge clk); bus_if.data_req = 1'b0;
        @(negedge clk); resetn = 1'b1;
        #1 chk1("rstmid_rel_req", bus_if.bus_req, 1'b0);
        @(negedge clk); bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'h66666666;
        #1 chk1("rstmid_stale_data_ok", bus_if.data_ok_o, 1'b0);
        chk1("rstmid_stale_inst_ok", bus_if.inst_ok, 1'b0);
        @(negedge clk); bus_if.bus_data_ok = 1'b0;
        run_txn(vecs[0]);

`ifdef BUS_ARB_PERF_EN
        chk1("perf_inst_nonzero", perf_i != 32'd0, 1'b1);
        chk1("perf_data_nonzero", perf_d != 32'd0, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
